// File: rtl/ser_wr_pkg.sv
// ser_wr_pkg -- shared definitions for the serial write-port deserializer.
//   SER_WR_DATA_W : data bits per frame (8)
//   SER_WR_ADDR_W : register sub-address width (4)
//   SER_WR_CNT_W  : bit counter width (counts 0..8)
//   ser_wr_state_e: frame FSM states
//   even_parity_ok: 1 when data plus parity bit holds an even number of ones
package ser_wr_pkg;

  localparam int SER_WR_DATA_W = 8;
  localparam int SER_WR_ADDR_W = 4;
  localparam int SER_WR_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_DONE  = 2'd3
  } ser_wr_state_e;

  function automatic logic even_parity_ok(input logic [SER_WR_DATA_W-1:0] data,
                                          input logic                     par_bit);
    return ~(^data ^ par_bit);
  endfunction

endpackage

// File: rtl/ser_wr_shreg.sv
// ser_wr_shreg -- 8-bit MSB-first shift register with load-clear and bit counter.
// Optional feature macro: SER_WR_PARITY_EN selects which data view is exported.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : clear data and bit counter (has priority over shift_en)
//   shift_en  : shift bit_in into the LSB, increment the counter
//   bit_in    : serial data bit
//   last      : counter says the next shift takes the final data bit
//   data      : (SER_WR_PARITY_EN) registered shift contents
//   data_nxt  : (default build) contents as they will be after shifting bit_in
module ser_wr_shreg
  import ser_wr_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     shift_en,
  input  logic                     bit_in,
  output logic                     last,
`ifdef SER_WR_PARITY_EN
  output logic [SER_WR_DATA_W-1:0] data
`else
  output logic [SER_WR_DATA_W-1:0] data_nxt
`endif
);

  logic [SER_WR_DATA_W-1:0] data_q, data_d, shifted;
  logic [SER_WR_CNT_W-1:0]  cnt_q, cnt_d;

  assign shifted = {data_q[SER_WR_DATA_W-2:0], bit_in};
  assign last    = (cnt_q == SER_WR_CNT_W'(SER_WR_DATA_W - 1));

`ifdef SER_WR_PARITY_EN
  assign data     = data_q;
`else
  assign data_nxt = shifted;
`endif

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      data_d = shifted;
      cnt_d  = cnt_q + SER_WR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ser_wr_deser.sv
// ser_wr_deser -- deserializes bus write cycles carrying one serial bit each
// into a data byte tagged with the register sub-address of the frame.
// Optional feature macro: SER_WR_PARITY_EN adds an even-parity bit after the data.
//   clk, rst   : clock, synchronous active-high reset
//   SSER       : serial-port select, active-low
//   BA13, BA12 : address window (BA13=0, BA12=1)
//   BA7_4      : register sub-address
//   BR_W       : bus direction, 1=read 0=write
//   SDWR       : serial write-data bit
//   rx_data    : last received byte
//   rx_addr    : sub-address captured with rx_data
//   rx_valid   : one-cycle pulse when rx_data/rx_addr update
//   rx_ferr    : one-cycle pulse on aborted frame or parity failure
//   busy       : frame in progress
module ser_wr_deser
  import ser_wr_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SSER,
  input  logic                     BA13,
  input  logic                     BA12,
  input  logic [SER_WR_ADDR_W-1:0] BA7_4,
  input  logic                     BR_W,
  input  logic                     SDWR,
  output logic [SER_WR_DATA_W-1:0] rx_data,
  output logic [SER_WR_ADDR_W-1:0] rx_addr,
  output logic                     rx_valid,
  output logic                     rx_ferr,
  output logic                     busy
);

  ser_wr_state_e            state_q, state_d;
  logic [SER_WR_ADDR_W-1:0] addr_q, addr_d;
  logic [SER_WR_DATA_W-1:0] rx_data_q, rx_data_d;
  logic [SER_WR_ADDR_W-1:0] rx_addr_q, rx_addr_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     rx_ferr_q, rx_ferr_d;
  logic                     busy_q, busy_d;

  logic qual, start, addr_ok, abort;
  logic sh_clr, sh_shift, sh_last;
`ifdef SER_WR_PARITY_EN
  logic [SER_WR_DATA_W-1:0] sh_data;
`else
  logic [SER_WR_DATA_W-1:0] sh_data_nxt;
`endif

  assign qual    = ~SSER & ~BA13 & BA12 & ~BR_W;
  assign start   = qual & SDWR;
  assign addr_ok = (BA7_4 == addr_q);
  // Deselect aborts regardless of cycle type; an address change only counts
  // on a qualifying write, so reads never disturb a frame.
  assign abort   = SSER | (qual & ~addr_ok);

  ser_wr_shreg u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clr      (sh_clr),
    .shift_en (sh_shift),
    .bit_in   (SDWR),
    .last     (sh_last),
`ifdef SER_WR_PARITY_EN
    .data     (sh_data)
`else
    .data_nxt (sh_data_nxt)
`endif
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rx_data_d  = rx_data_q;
    rx_addr_d  = rx_addr_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    sh_clr     = 1'b0;
    sh_shift   = 1'b0;

    case (state_q)
      // DONE behaves like IDLE for start detection so a start bit in the
      // pulse cycle begins the next frame without losing it.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SHIFT;
          addr_d  = BA7_4;
          sh_clr  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          state_d   = ST_IDLE;
          rx_ferr_d = 1'b1;
          sh_clr    = 1'b1;
        end else if (qual) begin
          sh_shift = 1'b1;
          if (sh_last) begin
`ifdef SER_WR_PARITY_EN
            state_d    = ST_PAR;
`else
            state_d    = ST_DONE;
            rx_data_d  = sh_data_nxt;
            rx_addr_d  = addr_q;
            rx_valid_d = 1'b1;
`endif
          end
        end
      end

`ifdef SER_WR_PARITY_EN
      ST_PAR: begin
        if (abort) begin
          state_d   = ST_IDLE;
          rx_ferr_d = 1'b1;
          sh_clr    = 1'b1;
        end else if (qual) begin
          if (even_parity_ok(sh_data, SDWR)) begin
            state_d    = ST_DONE;
            rx_data_d  = sh_data;
            rx_addr_d  = addr_q;
            rx_valid_d = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            rx_ferr_d = 1'b1;
            sh_clr    = 1'b1;
          end
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SHIFT) || (state_d == ST_PAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rx_data_q  <= '0;
      rx_addr_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rx_data_q  <= rx_data_d;
      rx_addr_q  <= rx_addr_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_addr  = rx_addr_q;
  assign rx_valid = rx_valid_q;
  assign rx_ferr  = rx_ferr_q;
  assign busy     = busy_q;

endmodule
